univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the register width in bits (N >= 2).
REQ-002 The block SHALL have parameter CW, default 3, giving the width of the burst step count.
REQ-003 clk  input  1  the single clock; all state SHALL update on the rising edge only.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 en  input  1  enables a single direct operation while idle.
REQ-006 mode  input  3  operation select (see REQ-011).
REQ-007 sin  input  1  serial input bit for shift modes.
REQ-008 pin  input  N  parallel load data.
REQ-009 start  input  1  burst request; cnt  input  CW  number of burst steps.
REQ-010 r  output  N  register contents; sout_r  output  1  equals r[0]; sout_l  output  1  equals r[N-1]; busy  output  1  burst in progress; done  output  1  one-cycle burst-complete pulse.

Function
REQ-011 The mode encoding SHALL be as follows (one step each):
- 000 hold
- 001 shift right, r <= {sin, r[N-1:1]}
- 010 shift left, r <= {r[N-2:0], sin}
- 011 rotate right, r <= {r[0], r[N-1:1]}
- 100 rotate left, r <= {r[N-2:0], r[N-1]}
- 101 parallel load, r <= pin
- 110 arithmetic shift right, r <= {r[N-1], r[N-1:1]}
- 111 clear, r <= 0
REQ-012 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-013 A start is qualifying when start=1, cnt != 0 and mode is in {001,010,011,100,110}.
REQ-014 In IDLE, a qualifying start at an edge SHALL take priority over en: the edge latches mode and cnt, moves to RUN, sets busy=1 and leaves r unchanged.
REQ-015 In IDLE without a qualifying start, en=1 SHALL apply the mode operation once at that edge; en=0 SHALL hold r.
REQ-016 A non-qualifying start SHALL be ignored: no state change and no done pulse, though the en path of REQ-015 still applies.
REQ-017 In RUN, each edge SHALL apply one step of the latched mode using the current sin, and decrement the remaining count.
REQ-018 In RUN, the inputs en, mode, cnt, pin and start SHALL be ignored.
REQ-019 Burst timing: with the qualifying start sampled at edge k, steps SHALL occur at edges k+1 through k+cnt.
REQ-020 busy SHALL be 1 from after edge k until edge k+cnt.
REQ-021 At edge k+cnt the FSM SHALL return to IDLE, and done SHALL be 1 for exactly the following cycle.
REQ-022 A new start SHALL be accepted at the edge where done is high, giving back-to-back bursts; done then drops and busy rises.
REQ-023 cnt values greater than N SHALL be legal: rotates wrap around, shifts fill fully with sin or the sign bit.
REQ-024 sout_r and sout_l SHALL be combinational from r, with no added latency.
REQ-025 busy and done SHALL never be high in the same cycle.

Reset
REQ-026 rst_n=0 at an edge SHALL set r=0, the FSM to IDLE, busy=0, done=0 and the remaining count to 0, overriding every other input.
REQ-027 Reset during RUN SHALL abort the burst with no done pulse.
REQ-028 The block SHALL have no initial-value dependence: all outputs are defined only after the first reset edge.

Verification (N=4, CW=3)
REQ-029 Bench SHALL cover: reset, then en=1, mode=001, sin=1 for 4 edges -> r = 1000, 1100, 1110, 1111; sout_r = 0, 0, 0, 1.
REQ-030 Bench SHALL cover: load pin=1011 (mode 101), then mode 100 for one edge -> 0111; reload 1011, then mode 011 for one edge -> 1101.
REQ-031 Bench SHALL cover: load 1000, then mode 110 for 2 edges -> 1100, 1110; then mode 010 with sin=1 for one edge -> 1101.
REQ-032 Bench SHALL cover: load 0001, then start=1, mode=100, cnt=3 -> busy high for 3 cycles, r = 0010, 0100, 1000, then done high for 1 cycle; toggling mode/en/pin during busy has no effect.
REQ-033 Bench SHALL cover: start=1 with cnt=0 and en=0 -> r, busy and done unchanged; start=1 with mode=101 and en=1 -> single load only, busy stays 0.
REQ-034 Bench SHALL cover: rst_n=0 on the second step of a cnt=5 burst -> next cycle r=0000, busy=0, and done stays low afterwards.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-step direct operations while idle, plus
// counted bursts that repeat one shift/rotate mode for cnt cycles.
//
// state | meaning
// IDLE  | waiting; en applies one operation, qualifying start launches a burst
// RUN   | burst in progress; one latched-mode step per edge until count expires
module univ_shift_reg #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic          sin,
    input  logic [N-1:0]  pin,
    input  logic          start,
    input  logic [CW-1:0] cnt,
    output logic [N-1:0]  r,
    output logic          sout_r,
    output logic          sout_l,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    logic [2:0]    mode_q;
    logic [CW-1:0] remaining;
    logic          qualify;

    function automatic logic [N-1:0] step_op(input logic [2:0] m,
                                             input logic [N-1:0] v,
                                             input logic s);
        logic [N-1:0] res;
        res = v;
        case (m)
            3'b000: res = v;
            3'b001: res = {s, v[N-1:1]};
            3'b010: res = {v[N-2:0], s};
            3'b011: res = {v[0], v[N-1:1]};
            3'b100: res = {v[N-2:0], v[N-1]};
            3'b101: res = pin;
            3'b110: res = {v[N-1], v[N-1:1]};
            3'b111: res = '0;
            default: res = v;
        endcase
        return res;
    endfunction

    // Only the shift/rotate modes make sense repeated; hold, load and clear
    // fall through to the en path instead.
    always_comb begin
        qualify = 1'b0;
        if (start && (cnt != '0)) begin
            case (mode)
                3'b001, 3'b010, 3'b011, 3'b100, 3'b110: qualify = 1'b1;
                default: qualify = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= '0;
            mode_q    <= 3'b000;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (qualify) begin
                        mode_q    <= mode;
                        remaining <= cnt;
                        state     <= RUN;
                        busy      <= 1'b1;
                    end else if (en) begin
                        r <= step_op(mode, r, sin);
                    end
                end
                RUN: begin
                    r         <= step_op(mode_q, r, sin);
                    remaining <= remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign sout_r = r[0];
    assign sout_l = r[N-1];

endmodule
